multi_alarm_core: RTL and testbench

Parametrised successor to the fixed single-alarm timekeeping path. It provides a BCD hh:mm:ss counter advanced by a synchronous 1 Hz strobe, NUM_ALARMS independently programmable alarms, and a ring/snooze/timeout state machine. It also generates an hourly chime pulse and 12/24-hour display conversion. It sits between the divider (tick source) and the select/decoder/reminder display path, and replaces the separate counter_sec/min/hour and alarm blocks.

---
 rtl/multi_alarm_core.sv | 219 +++++++++++++++++++++
 tb/tb_multi_alarm_core.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/multi_alarm_core.sv
// BCD hh:mm:ss timekeeper with NUM_ALARMS programmable alarms, ring/snooze/timeout
// control, hourly chime and 12/24-hour display conversion.
module multi_alarm_core #(
    parameter int NUM_ALARMS = 4,
    parameter int SNOOZE_MIN = 5,
    parameter int RING_SEC   = 60,
    parameter int CHIME_EN   = 1,
    localparam int AW = (NUM_ALARMS > 1) ? $clog2(NUM_ALARMS) : 1
) (
    input  logic          CP,
    input  logic          _CR,
    input  logic          tick,
    input  logic          load_time,
    input  logic [7:0]    load_hour,
    input  logic [7:0]    load_min,
    input  logic [7:0]    load_sec,
    input  logic          alarm_wr,
    input  logic [AW-1:0] alarm_sel,
    input  logic [7:0]    alarm_hour,
    input  logic [7:0]    alarm_min,
    input  logic          alarm_en,
    input  logic          time_mode,
    input  logic          snooze,
    input  logic          dismiss,
    output logic [7:0]    show_hour,
    output logic [7:0]    show_min,
    output logic [7:0]    show_sec,
    output logic [7:0]    disp_hour,
    output logic          pm,
    output logic          ringing,
    output logic          snoozing,
    output logic [AW-1:0] ring_id,
    output logic          chime,
    output logic          load_err
);

    typedef enum logic [1:0] {IDLE, RING, SNOOZE} state_t;

    typedef struct packed {
        logic [7:0] hour;
        logic [7:0] min;
        logic       en;
    } slot_t;

    function automatic logic bcd_ok(input logic [7:0] v, input logic [7:0] lim);
        return (v[7:4] <= 4'd9) && (v[3:0] <= 4'd9) && (v <= lim);
    endfunction

    function automatic logic [7:0] bcd_inc(input logic [7:0] v);
        return (v[3:0] == 4'd9) ? {v[7:4] + 4'd1, 4'd0} : {v[7:4], v[3:0] + 4'd1};
    endfunction

    state_t        state, state_nx;
    slot_t         slots [NUM_ALARMS];
    logic [7:0]    ring_cnt, ring_cnt_nx;
    logic [11:0]   snz_cnt, snz_cnt_nx;
    logic [AW-1:0] ring_id_nx;
    logic          tick_upd;
    logic [7:0]    sec_nx, min_nx, hour_nx;
    logic          time_ok, sel_ok, wr_ok, kill;
    logic          hit, match;
    logic [AW-1:0] hit_id;
    logic [4:0]    hour_bin, hour_pm;

    assign time_ok = bcd_ok(load_hour, 8'h23) && bcd_ok(load_min, 8'h59)
                  && bcd_ok(load_sec, 8'h59);
    assign sel_ok  = int'(alarm_sel) < NUM_ALARMS;
    assign wr_ok   = alarm_wr && sel_ok && bcd_ok(alarm_hour, 8'h23)
                  && bcd_ok(alarm_min, 8'h59);

    // Ripple the BCD carry sec -> min -> hour.
    always_comb begin
        sec_nx  = (show_sec == 8'h59) ? 8'h00 : bcd_inc(show_sec);
        min_nx  = show_min;
        hour_nx = show_hour;
        if (show_sec == 8'h59) begin
            min_nx = (show_min == 8'h59) ? 8'h00 : bcd_inc(show_min);
            if (show_min == 8'h59)
                hour_nx = (show_hour == 8'h23) ? 8'h00 : bcd_inc(show_hour);
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    always_ff @(posedge CP or posedge _CR) begin
        if (_CR) begin
            show_hour <= 8'h00;
            show_min  <= 8'h00;
            show_sec  <= 8'h00;
            tick_upd  <= 1'b0;
            chime     <= 1'b0;
            load_err  <= 1'b0;
        end else begin
            load_err <= (load_time && !time_ok) || (alarm_wr && !wr_ok);
            chime    <= 1'b0;
            tick_upd <= 1'b0;
            if (load_time) begin
                if (time_ok) begin
                    show_hour <= load_hour;
                    show_min  <= load_min;
                    show_sec  <= load_sec;
                end
            end else if (tick) begin
                show_hour <= hour_nx;
                show_min  <= min_nx;
                show_sec  <= sec_nx;
                tick_upd  <= (sec_nx == 8'h00);
                chime     <= (CHIME_EN != 0) && (min_nx == 8'h00) && (sec_nx == 8'h00);
            end
        end
    end

    // NOTE: the alarm table is a reset memory because alarms must power up
    // disabled; a non-reset RAM could fire on garbage after reset.
    always_ff @(posedge CP or posedge _CR) begin
        if (_CR) begin
            for (int i = 0; i < NUM_ALARMS; i++) slots[i] <= '0;
        end else if (wr_ok) begin
            slots[alarm_sel] <= '{hour: alarm_hour, min: alarm_min, en: alarm_en};
        end
    end

    // Downward scan so the lowest matching index is the last one assigned.
    always_comb begin
        hit    = 1'b0;
        hit_id = '0;
        for (int i = NUM_ALARMS - 1; i >= 0; i--) begin
            if (slots[i].en && slots[i].hour == show_hour && slots[i].min == show_min) begin
                hit    = 1'b1;
                hit_id = AW'(i);
            end
        end
        match = hit && tick_upd;
    end

    assign kill = wr_ok && !alarm_en && (alarm_sel == ring_id);

    always_ff @(posedge CP or posedge _CR) begin
        if (_CR) begin
            state    <= IDLE;
            ring_id  <= '0;
            ring_cnt <= 8'd0;
            snz_cnt  <= 12'd0;
        end else begin
            state    <= state_nx;
            ring_id  <= ring_id_nx;
            ring_cnt <= ring_cnt_nx;
            snz_cnt  <= snz_cnt_nx;
        end
    end

    // NOTE: every output of this block gets a default first, so no path can
    // leave a value unassigned and infer a latch.
    always_comb begin
        state_nx    = state;
        ring_id_nx  = ring_id;
        ring_cnt_nx = ring_cnt;
        snz_cnt_nx  = snz_cnt;
        unique case (state)
            IDLE: begin
                if (match) begin
                    state_nx    = RING;
                    ring_id_nx  = hit_id;
                    ring_cnt_nx = 8'd0;
                end
            end
            RING: begin
                if (dismiss || kill) begin
                    state_nx = IDLE;
                end else if (snooze) begin
                    state_nx   = SNOOZE;
                    snz_cnt_nx = 12'(SNOOZE_MIN * 60);
                end else if (tick) begin
                    if (ring_cnt == 8'(RING_SEC - 1)) state_nx = IDLE;
                    else ring_cnt_nx = ring_cnt + 8'd1;
                end
            end
            SNOOZE: begin
                if (dismiss || kill) begin
                    state_nx = IDLE;
                end else if (match) begin
                    state_nx    = RING;
                    ring_id_nx  = hit_id;
                    ring_cnt_nx = 8'd0;
                end else if (tick) begin
                    snz_cnt_nx = snz_cnt - 12'd1;
                    if (snz_cnt == 12'd1) begin
                        state_nx    = RING;
                        ring_cnt_nx = 8'd0;
                    end
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    assign ringing  = (state == RING);
    assign snoozing = (state == SNOOZE);

    // 12 h view: afternoon hours are rebuilt in BCD from a binary hour - 12.
    always_comb begin
        hour_bin  = 5'(show_hour[7:4]) * 5'd10 + 5'(show_hour[3:0]);
        hour_pm   = hour_bin - 5'd12;
        disp_hour = show_hour;
        pm        = 1'b0;
        if (time_mode) begin
            if (show_hour == 8'h00) begin
                disp_hour = 8'h12;
            end else if (show_hour == 8'h12) begin
                pm = 1'b1;
            end else if (show_hour > 8'h12) begin
                pm        = 1'b1;
                disp_hour = (hour_pm >= 5'd10) ? {4'd1, 4'(hour_pm - 5'd10)}
                                               : {4'd0, hour_pm[3:0]};
            end
        end
    end

endmodule

// File: tb/tb_multi_alarm_core.sv
// Directed bench for multi_alarm_core: a load/display vector table followed by
// hand sequences for rollover, rejects, alarm priority, snooze, timeout and reset.
module tb_multi_alarm_core;

    // Three slots leave alarm_sel = 3 as an encodable out-of-range index.
    localparam int NA = 3;
    localparam int AW = 2;

    logic          CP = 1'b0;
    logic          _CR = 1'b1;
    logic          tick = 1'b0, load_time = 1'b0;
    logic [7:0]    load_hour = '0, load_min = '0, load_sec = '0;
    logic          alarm_wr = 1'b0;
    logic [AW-1:0] alarm_sel = '0;
    logic [7:0]    alarm_hour = '0, alarm_min = '0;
    logic          alarm_en = 1'b0, time_mode = 1'b0, snooze = 1'b0, dismiss = 1'b0;
    logic [7:0]    show_hour, show_min, show_sec, disp_hour;
    logic          pm, ringing, snoozing, chime, load_err;
    logic [AW-1:0] ring_id;

    int n_vec = 0;
    int n_err = 0;

    multi_alarm_core #(.NUM_ALARMS(NA), .SNOOZE_MIN(1), .RING_SEC(60), .CHIME_EN(1)) dut (
        .CP(CP), ._CR(_CR), .tick(tick), .load_time(load_time),
        .load_hour(load_hour), .load_min(load_min), .load_sec(load_sec),
        .alarm_wr(alarm_wr), .alarm_sel(alarm_sel), .alarm_hour(alarm_hour),
        .alarm_min(alarm_min), .alarm_en(alarm_en), .time_mode(time_mode),
        .snooze(snooze), .dismiss(dismiss), .show_hour(show_hour),
        .show_min(show_min), .show_sec(show_sec), .disp_hour(disp_hour), .pm(pm),
        .ringing(ringing), .snoozing(snoozing), .ring_id(ring_id), .chime(chime),
        .load_err(load_err)
    );

    always #5 CP = ~CP;

    typedef struct {
        logic [7:0] h, m, s;
        logic       mode;
        logic [7:0] eh, em, es, ed;
        logic       epm, eerr;
    } vec_t;

    vec_t vecs [11];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge CP);
        #1;
    endtask

    task automatic load(input logic [7:0] h, input logic [7:0] m, input logic [7:0] s);
        load_hour = h; load_min = m; load_sec = s;
        load_time = 1'b1;
        step();
        load_time = 1'b0;
    endtask

    task automatic wr(input logic [AW-1:0] sel, input logic [7:0] h, input logic [7:0] m,
                      input logic en);
        alarm_sel = sel; alarm_hour = h; alarm_min = m; alarm_en = en;
        alarm_wr = 1'b1;
        step();
        alarm_wr = 1'b0;
    endtask

    task automatic pulse_tick();
        tick = 1'b1;
        step();
        tick = 1'b0;
    endtask

    initial begin
        #500_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        //            h      m      s    mode  exp h  exp m  exp s  disp   pm    err
        vecs[0]  = '{8'h13, 8'h05, 8'h00, 1'b1, 8'h13, 8'h05, 8'h00, 8'h01, 1'b1, 1'b0};
        vecs[1]  = '{8'h13, 8'h05, 8'h00, 1'b0, 8'h13, 8'h05, 8'h00, 8'h13, 1'b0, 1'b0};
        vecs[2]  = '{8'h00, 8'h10, 8'h20, 1'b1, 8'h00, 8'h10, 8'h20, 8'h12, 1'b0, 1'b0};
        vecs[3]  = '{8'h12, 8'h34, 8'h56, 1'b1, 8'h12, 8'h34, 8'h56, 8'h12, 1'b1, 1'b0};
        vecs[4]  = '{8'h24, 8'h00, 8'h00, 1'b1, 8'h12, 8'h34, 8'h56, 8'h12, 1'b1, 1'b1};
        vecs[5]  = '{8'h10, 8'h00, 8'h5A, 1'b1, 8'h12, 8'h34, 8'h56, 8'h12, 1'b1, 1'b1};
        vecs[6]  = '{8'h09, 8'h07, 8'h08, 1'b1, 8'h09, 8'h07, 8'h08, 8'h09, 1'b0, 1'b0};
        vecs[7]  = '{8'h1A, 8'h00, 8'h00, 1'b1, 8'h09, 8'h07, 8'h08, 8'h09, 1'b0, 1'b1};
        vecs[8]  = '{8'h23, 8'h59, 8'h59, 1'b1, 8'h23, 8'h59, 8'h59, 8'h11, 1'b1, 1'b0};
        vecs[9]  = '{8'h00, 8'h60, 8'h00, 1'b0, 8'h23, 8'h59, 8'h59, 8'h23, 1'b0, 1'b1};
        vecs[10] = '{8'h20, 8'h00, 8'h00, 1'b1, 8'h20, 8'h00, 8'h00, 8'h08, 1'b1, 1'b0};

        repeat (2) @(posedge CP);
        #1 _CR = 1'b0;
        check("rst_hour", show_hour, 8'h00);
        check("rst_min", show_min, 8'h00);
        check("rst_sec", show_sec, 8'h00);
        check("rst_ringing", ringing, 0);
        check("rst_snoozing", snoozing, 0);
        check("rst_ring_id", ring_id, 0);
        check("rst_chime", chime, 0);
        check("rst_load_err", load_err, 0);

        for (int i = 0; i < 11; i++) begin
            time_mode = vecs[i].mode;
            load(vecs[i].h, vecs[i].m, vecs[i].s);
            check($sformatf("vec%0d_err", i), load_err, vecs[i].eerr);
            check($sformatf("vec%0d_hour", i), show_hour, vecs[i].eh);
            check($sformatf("vec%0d_min", i), show_min, vecs[i].em);
            check($sformatf("vec%0d_sec", i), show_sec, vecs[i].es);
            check($sformatf("vec%0d_disp", i), disp_hour, vecs[i].ed);
            check($sformatf("vec%0d_pm", i), pm, vecs[i].epm);
            check($sformatf("vec%0d_chime", i), chime, 0);
            step();
            check($sformatf("vec%0d_err_clear", i), load_err, 0);
        end
        time_mode = 1'b0;

        // Tick coincident with a load is dropped.
        tick = 1'b1;
        load(8'h05, 8'h06, 8'h07);
        tick = 1'b0;
        check("load_tick_sec", show_sec, 8'h07);
        check("load_tick_min", show_min, 8'h06);
        step();

        // Load that lands on hh:00:00 never chimes.
        load(8'h08, 8'h00, 8'h00);
        check("load_no_chime", chime, 0);
        step();

        load(8'h23, 8'h59, 8'h58);
        step();
        pulse_tick();
        check("roll1_sec", show_sec, 8'h59);
        check("roll1_chime", chime, 0);
        step();
        pulse_tick();
        check("roll2_hour", show_hour, 8'h00);
        check("roll2_min", show_min, 8'h00);
        check("roll2_sec", show_sec, 8'h00);
        check("roll2_chime", chime, 1);
        step();
        check("roll2_chime_clear", chime, 0);

        wr(2'd3, 8'h07, 8'h30, 1'b1);
        check("wr_sel_reject", load_err, 1);
        step();
        wr(2'd0, 8'h07, 8'h60, 1'b1);
        check("wr_min_reject", load_err, 1);
        step();

        wr(2'd1, 8'h07, 8'h30, 1'b1);
        check("wr1_ok", load_err, 0);
        wr(2'd2, 8'h07, 8'h30, 1'b1);
        check("wr2_ok", load_err, 0);
        load(8'h07, 8'h30, 8'h00);
        repeat (3) step();
        check("load_no_ring", ringing, 0);
        load(8'h07, 8'h29, 8'h59);
        step();
        pulse_tick();
        check("prio_min", show_min, 8'h30);
        check("prio_pending", ringing, 0);
        step();
        check("prio_ringing", ringing, 1);
        check("prio_ring_id", ring_id, 1);

        snooze = 1'b1;
        step();
        snooze = 1'b0;
        check("snz_snoozing", snoozing, 1);
        check("snz_not_ringing", ringing, 0);
        repeat (59) begin
            step();
            pulse_tick();
        end
        check("snz_59_still", snoozing, 1);
        step();
        pulse_tick();
        check("snz_60_ringing", ringing, 1);
        check("snz_60_ring_id", ring_id, 1);
        step();
        dismiss = 1'b1;
        snooze  = 1'b1;
        step();
        dismiss = 1'b0;
        snooze  = 1'b0;
        check("dis_snz_ringing", ringing, 0);
        check("dis_snz_snoozing", snoozing, 0);

        wr(2'd0, 8'h07, 8'h35, 1'b1);
        load(8'h07, 8'h34, 8'h59);
        step();
        pulse_tick();
        step();
        check("to_ringing", ringing, 1);
        check("to_ring_id", ring_id, 0);
        repeat (59) begin
            pulse_tick();
            step();
        end
        check("to_59_still", ringing, 1);
        pulse_tick();
        check("to_60_stop", ringing, 0);
        step();

        load(8'h07, 8'h29, 8'h59);
        step();
        pulse_tick();
        step();
        check("dis_slot_ringing", ringing, 1);
        check("dis_slot_ring_id", ring_id, 1);
        wr(2'd2, 8'h07, 8'h30, 1'b0);
        check("dis_other_slot", ringing, 1);
        wr(2'd1, 8'h07, 8'h30, 1'b0);
        check("dis_ring_slot", ringing, 0);
        step();

        // Asynchronous reset out of RING.
        load(8'h07, 8'h34, 8'h59);
        step();
        pulse_tick();
        step();
        check("rst_pre_ringing", ringing, 1);
        _CR = 1'b1;
        #1;
        check("rst_async_ringing", ringing, 0);
        check("rst_async_hour", show_hour, 8'h00);
        step();
        _CR = 1'b0;
        step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
